bmp180_conv_timer: RTL and testbench

- Sequencer for a BMP180 conversion wait.
- On a start request it latches the measurement type and oversampling (OSS), and produces the control byte for register 0xF4.
- It drives the enable and clear inputs of the shared clock-count timer, compares that timer's count against the maximum conversion time for the selected mode, and pulses done.
- It sits between the measurement-command logic upstream and the timer counter/I2C read sequencer downstream.

---
 rtl/bmp180_pkg.sv | 22 ++
 rtl/bmp180_conv_lut.sv | 33 +++
 rtl/bmp180_conv_timer.sv | 106 ++++++++++
 tb/tb_bmp180_conv_timer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bmp180_pkg.sv
// Shared types and constants for the BMP180 conversion-wait sequencer.
package bmp180_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] CTRL_MEAS_ADDR = 8'hF4;
  localparam logic [7:0] CMD_TEMP       = 8'h2E;
  localparam logic [7:0] CMD_PRESS      = 8'h34;

  // Maximum conversion times from the BMP180 datasheet, in seconds.
  localparam real T_CONV_TEMP_S = 0.0045;
  localparam real T_CONV_OSS0_S = 0.0045;
  localparam real T_CONV_OSS1_S = 0.0075;
  localparam real T_CONV_OSS2_S = 0.0135;
  localparam real T_CONV_OSS3_S = 0.0255;

endpackage

// File: rtl/bmp180_conv_lut.sv
// Maps {mode, OSS} to the conversion threshold in clocks and the 0xF4 control byte.
module bmp180_conv_lut
  import bmp180_pkg::*;
#(
  parameter int unsigned N_TEMP        = 225_000,
  parameter int unsigned N_OSS0        = 225_000,
  parameter int unsigned N_OSS1        = 375_000,
  parameter int unsigned N_OSS2        = 675_000,
  parameter int unsigned N_OSS3        = 1_275_000,
  parameter int unsigned CNT_MSR_MX_SZ = 21
) (
  input  logic                     i_mode,
  input  logic [1:0]               i_oss,
  output logic [CNT_MSR_MX_SZ-1:0] o_thr,
  output logic [7:0]               o_ctrl
);

  always_comb begin
    o_thr  = CNT_MSR_MX_SZ'(N_TEMP);
    o_ctrl = CMD_TEMP;
    if (i_mode) begin
      // OSS occupies bits [7:6] of the pressure command.
      o_ctrl = {i_oss, CMD_PRESS[5:0]};
      unique case (i_oss)
        2'd0: o_thr = CNT_MSR_MX_SZ'(N_OSS0);
        2'd1: o_thr = CNT_MSR_MX_SZ'(N_OSS1);
        2'd2: o_thr = CNT_MSR_MX_SZ'(N_OSS2);
        2'd3: o_thr = CNT_MSR_MX_SZ'(N_OSS3);
      endcase
    end
  end

endmodule

// File: rtl/bmp180_conv_timer.sv
// BMP180 conversion-wait sequencer: latches the mode, drives the shared timer,
// and pulses O_DONE once the selected conversion time has elapsed.
module bmp180_conv_timer
  import bmp180_pkg::*;
#(
  parameter int unsigned FPGA_CLK      = 50_000_000,
  parameter int unsigned N_TEMP        = 225_000,
  parameter int unsigned N_OSS0        = 225_000,
  parameter int unsigned N_OSS1        = 375_000,
  parameter int unsigned N_OSS2        = 675_000,
  parameter int unsigned N_OSS3        = 1_275_000,
  parameter int unsigned CNT_MSR_MX_SZ = 21
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     I_START,
  input  logic                     I_MODE,
  input  logic [1:0]               I_OSS,
  input  logic                     I_ABORT,
  input  logic [CNT_MSR_MX_SZ-1:0] I_CNT,
  output logic                     O_CNT_EN,
  output logic                     O_CNT_RST,
  output logic                     O_BUSY,
  output logic                     O_DONE,
  output logic [7:0]               O_CTRL_BYTE
);

  if (FPGA_CLK == 0) begin : g_bad_clk
    $error("FPGA_CLK must be non-zero");
  end
  if ((64'd1 << CNT_MSR_MX_SZ) <= 64'(N_OSS3)) begin : g_cnt_too_narrow
    $error("CNT_MSR_MX_SZ too narrow for N_OSS3");
  end

  state_t                   r_state, w_next;
  logic [CNT_MSR_MX_SZ-1:0] r_thr;
  logic [7:0]               r_ctrl;
  logic [CNT_MSR_MX_SZ-1:0] w_thr;
  logic [7:0]               w_ctrl;
  logic                     w_accept;
  logic                     w_elapsed;

  bmp180_conv_lut #(
    .N_TEMP       (N_TEMP),
    .N_OSS0       (N_OSS0),
    .N_OSS1       (N_OSS1),
    .N_OSS2       (N_OSS2),
    .N_OSS3       (N_OSS3),
    .CNT_MSR_MX_SZ(CNT_MSR_MX_SZ)
  ) u_lut (
    .i_mode(I_MODE),
    .i_oss (I_OSS),
    .o_thr (w_thr),
    .o_ctrl(w_ctrl)
  );

  assign w_accept  = (r_state == S_IDLE) && I_START && !I_ABORT;
  // I_CNT lags the increments by one cycle, hence THR-1.
  assign w_elapsed = I_CNT >= (r_thr - CNT_MSR_MX_SZ'(1));

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_thr   <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_thr  <= w_thr;
        r_ctrl <= w_ctrl;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    O_CNT_EN  = 1'b0;
    O_CNT_RST = 1'b1;
    O_BUSY    = 1'b0;
    O_DONE    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CLR;
      end
      S_CLR: begin
        O_BUSY = 1'b1;
        w_next = I_ABORT ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        O_CNT_EN  = 1'b1;
        O_CNT_RST = 1'b0;
        O_BUSY    = 1'b1;
        if (I_ABORT)        w_next = S_IDLE;
        else if (w_elapsed) w_next = S_DONE;
      end
      S_DONE: begin
        O_BUSY = 1'b1;
        O_DONE = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  assign O_CTRL_BYTE = r_ctrl;

endmodule

// File: tb/tb_bmp180_conv_timer.sv
// Directed bench for bmp180_conv_timer with a behavioural model of the shared timer.
module tb_bmp180_conv_timer;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST_n = 1'b0;
  logic         I_START = 1'b0;
  logic         I_MODE = 1'b0;
  logic [1:0]   I_OSS = 2'd0;
  logic         I_ABORT = 1'b0;
  logic [W-1:0] tb_cnt = '0;
  logic         O_CNT_EN, O_CNT_RST, O_BUSY, O_DONE;
  logic [7:0]   O_CTRL_BYTE;

  int n_checks = 0;
  int n_errors = 0;
  int n_done;
  int lat;

  always #5 CLK = ~CLK;

  // Timer: increment has priority over clear; output registered.
  always @(posedge CLK) begin
    if (O_CNT_EN)       tb_cnt <= tb_cnt + 8'd1;
    else if (O_CNT_RST) tb_cnt <= '0;
  end

  bmp180_conv_timer #(
    .FPGA_CLK     (50_000_000),
    .N_TEMP       (10),
    .N_OSS0       (10),
    .N_OSS1       (16),
    .N_OSS2       (28),
    .N_OSS3       (52),
    .CNT_MSR_MX_SZ(W)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .I_START    (I_START),
    .I_MODE     (I_MODE),
    .I_OSS      (I_OSS),
    .I_ABORT    (I_ABORT),
    .I_CNT      (tb_cnt),
    .O_CNT_EN   (O_CNT_EN),
    .O_CNT_RST  (O_CNT_RST),
    .O_BUSY     (O_BUSY),
    .O_DONE     (O_DONE),
    .O_CTRL_BYTE(O_CTRL_BYTE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic count_done(input int k, output int c);
    c = 0;
    repeat (k) begin
      step();
      if (O_DONE) c++;
    end
  endtask

  // Cycle 1 is the one right after the edge that samples I_START.
  task automatic run_conv(input logic mode, input logic [1:0] oss, input logic [7:0] exp_ctrl,
                          input int exp_lat, input int exp_cnt, input logic poke_done);
    int n;
    I_MODE = mode; I_OSS = oss; I_START = 1'b1;
    step();
    I_START = 1'b0;
    n = 1;
    chk("ctrl", O_CTRL_BYTE, exp_ctrl);
    chk("busy_clr", O_BUSY, 1);
    while (!O_DONE && n < 200) begin
      step();
      n++;
    end
    chk("latency", n, exp_lat);
    chk("cnt_at_done", tb_cnt, exp_cnt);
    chk("en_rst_done", {O_CNT_EN, O_CNT_RST}, 2'b01);
    if (poke_done) begin
      I_START = 1'b1; I_MODE = 1'b1; I_OSS = 2'd2; I_ABORT = 1'b1;
    end
    step();
    I_START = 1'b0; I_ABORT = 1'b0;
    chk("busy_after", O_BUSY, 0);
    chk("done_after", O_DONE, 0);
    if (poke_done) begin
      chk("ctrl_after_done_start", O_CTRL_BYTE, exp_ctrl);
      step();
      chk("busy_after_done_start", O_BUSY, 0);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) step();
    chk("rst_busy", O_BUSY, 0);
    chk("rst_done", O_DONE, 0);
    chk("rst_en", O_CNT_EN, 0);
    chk("rst_cntrst", O_CNT_RST, 1);
    chk("rst_ctrl", O_CTRL_BYTE, 8'h00);
    RST_n = 1'b1;
    step();

    // Temperature; OSS ignored. Also a start+abort during DONE is ignored.
    run_conv(1'b0, 2'd3, 8'h2E, 12, 10, 1'b1);

    // Pressure sweep.
    run_conv(1'b1, 2'd0, 8'h34, 12, 10, 1'b0);
    run_conv(1'b1, 2'd1, 8'h74, 18, 16, 1'b0);
    run_conv(1'b1, 2'd2, 8'hB4, 30, 28, 1'b0);
    run_conv(1'b1, 2'd3, 8'hF4, 54, 52, 1'b0);

    // Abort in WAIT cycle 5 of OSS=2.
    I_MODE = 1'b1; I_OSS = 2'd2; I_START = 1'b1;
    step();
    I_START = 1'b0;
    repeat (5) step();
    chk("abort_pre_busy", O_BUSY, 1);
    chk("abort_pre_en", O_CNT_EN, 1);
    I_ABORT = 1'b1;
    step();
    I_ABORT = 1'b0;
    chk("abort_busy", O_BUSY, 0);
    chk("abort_en_rst", {O_CNT_EN, O_CNT_RST}, 2'b01);
    chk("abort_done", O_DONE, 0);
    count_done(40, n_done);
    chk("abort_no_done", n_done, 0);
    chk("abort_ctrl", O_CTRL_BYTE, 8'hB4);

    // Re-start while busy is ignored.
    I_MODE = 1'b1; I_OSS = 2'd3; I_START = 1'b1;
    step();
    I_START = 1'b0;
    lat = 1;
    repeat (3) begin step(); lat++; end
    I_MODE = 1'b1; I_OSS = 2'd0; I_START = 1'b1;
    step(); lat++;
    I_START = 1'b0;
    chk("restart_ctrl", O_CTRL_BYTE, 8'hF4);
    while (!O_DONE && lat < 200) begin step(); lat++; end
    chk("restart_latency", lat, 54);
    step();
    chk("restart_busy_after", O_BUSY, 0);

    // Simultaneous start+abort in IDLE.
    I_MODE = 1'b0; I_START = 1'b1; I_ABORT = 1'b1;
    step();
    I_START = 1'b0; I_ABORT = 1'b0;
    chk("sa_busy", O_BUSY, 0);
    chk("sa_ctrl", O_CTRL_BYTE, 8'hF4);
    step();
    chk("sa_busy2", O_BUSY, 0);

    // Reset mid-WAIT.
    I_MODE = 1'b1; I_OSS = 2'd1; I_START = 1'b1;
    step();
    I_START = 1'b0;
    repeat (4) step();
    chk("mrst_pre_busy", O_BUSY, 1);
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    chk("mrst_busy", O_BUSY, 0);
    chk("mrst_done", O_DONE, 0);
    chk("mrst_en_rst", {O_CNT_EN, O_CNT_RST}, 2'b01);
    chk("mrst_ctrl", O_CTRL_BYTE, 8'h00);
    count_done(25, n_done);
    chk("mrst_no_done", n_done, 0);
    run_conv(1'b1, 2'd1, 8'h74, 18, 16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
